multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Main sequencer for the multi-cycle RV32I core: Moore FSM that steps the shared ALU, memory and register
//  file through FETCH/DECODE/EXECUTE/WRITEBACK. Drives datapath mux selects, write enables and the 2-bit
//  alu_op consumed by ALUControlUnit. Also counts retired instructions and flags illegal opcodes.
// PARAMETERS
//  INSTRET_W   32   width of retired-instruction counter (wraps modulo 2^INSTRET_W)
// PORTS
//  clk           in   1          core clock, rising edge
//  rst           in   1          asynchronous, active-high reset
//  opcode        in   7          instr[6:0] from instruction register
//  zero          in   1          ALU zero flag (valid in BEQ state)
//  mem_ready     in   1          memory access complete (present only with MC_MEM_WAIT_EN)
//  pc_write      out  1          PC load enable = pc_update | (branch & zero)
//  adr_src       out  1          0: PC, 1: ALU-out register drives memory address
//  mem_write     out  1          data memory write enable
//  ir_write      out  1          instruction register (and old_pc) load enable
//  reg_write     out  1          register file write enable
//  result_src    out  2          00 alu_out reg, 01 mem data reg, 10 alu_result
//  alu_src_a     out  2          00 PC, 01 old_pc, 10 rs1 reg
//  alu_src_b     out  2          00 rs2 reg, 01 imm_ext, 10 constant 4
//  imm_src       out  2          00 I, 01 S, 10 B, 11 J (decoded from opcode, combinational)
//  alu_op        out  2          00 add, 01 sub, 10 funct-decoded
//  instr_retired out  1          1-cycle pulse on final cycle of each legal instruction
//  illegal_instr out  1          1-cycle pulse in DECODE when opcode not supported
//  instret       out  INSTRET_W  retired-instruction count
// BEHAVIOUR
//  - States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL. State reg only
//    flop besides instret; all outputs except instret decoded from state (+opcode/zero/mem_ready).
//  - rst (async) -> state=FETCH, instret=0; outputs immediately equal FETCH decode. Reset mid-instruction
//    abandons it; no writes issued after rst asserts.
//  - FETCH: adr_src0, ir_write1, a=00,b=10,op=00, result_src=10, pc_update1 -> DECODE.
//  - DECODE: a=01,b=01,op=00 (branch target). Next by opcode: 0000011/0100011->MEMADR, 0110011->EXECR,
//    0010011->EXECI, 1100011->BEQ, 1101111->JAL, other->FETCH with illegal_instr=1 (no count).
//  - MEMADR: a=10,b=01,op=00 -> MEMREAD if opcode==0000011 else MEMWRITE.
//  - MEMREAD: adr_src1, result_src00 -> MEMWB. MEMWB: result_src01, reg_write1, retire -> FETCH.
//  - MEMWRITE: adr_src1, result_src00, mem_write1, retire -> FETCH.
//  - EXECR: a=10,b=00,op=10 -> ALUWB. EXECI: a=10,b=01,op=10 -> ALUWB.
//  - ALUWB: result_src00, reg_write1, retire -> FETCH.
//  - BEQ: a=10,b=00,op=01, result_src00, branch1, retire -> FETCH.
//  - JAL: a=01,b=10,op=00, result_src00, pc_update1 -> ALUWB (retire counted once, in ALUWB).
//  - Unlisted outputs 0 in every state. Latencies: lw 5, sw 4, R/I 4, beq 3, jal 4 cycles.
//  - instret increments on clk edge where instr_retired=1; all-ones +1 wraps to 0.
//  - Unreachable state encodings -> FETCH next cycle, all enables 0.
// CONFIGURATION
//  MC_MEM_WAIT_EN defined: mem_ready port exists; FETCH, MEMREAD, MEMWRITE hold while mem_ready=0.
//   In FETCH, ir_write and pc_update assert only when mem_ready=1; mem_write held 1 through MEMWRITE,
//   retire pulse only on the mem_ready=1 cycle. Illegal/retire counts unaffected by wait length.
//  Undefined: no mem_ready port; every memory state is exactly one cycle (as listed above).
// STRUCTURE
//  - Shared package mc_ctrl_pkg: state enum/localparams, opcode constants (OP_LW, OP_SW, OP_R, OP_I,
//    OP_BEQ, OP_JAL), result_src/alu_src/imm_src/alu_op select encodings (also used by datapath).
//  - One sub-module: mc_imm_src_decoder (opcode -> imm_src, purely combinational).
//  - FSM next-state, output decode and instret counter in this module.
// TESTING
//  - rst=1 mid-EXECR, release -> next cycle state FETCH, ir_write=1, reg_write=0, instret=0.
//  - opcode=0110011 from FETCH -> FETCH,DECODE,EXECR,ALUWB; reg_write=1 only in cycle 4; instret +1.
//  - opcode=1100011, zero=1 in BEQ -> pc_write=1 in BEQ cycle; zero=0 -> pc_write=0; 3 cycles each.
//  - opcode=0000011 -> 5 cycles, result_src=01 with reg_write in MEMWB; opcode=0100011 -> mem_write in cycle 4.
//  - opcode=1111111 -> illegal_instr pulses in DECODE, back to FETCH, instret unchanged.
//  - MC_MEM_WAIT_EN, mem_ready=0 for 3 cycles in FETCH -> ir_write/pc_write 0 until ready; INSTRET_W=4,
//    16 R-type instrs from 0 -> instret wraps to 0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path.
// Holds the sequencer state encoding, the supported opcodes and the select
// encodings that the datapath muxes and the ALU control unit also decode.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    // instr[6:0] values of the supported instruction classes
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // result_src: what is written back / routed to the PC
    localparam logic [1:0] RES_ALU_OUT    = 2'b00;
    localparam logic [1:0] RES_MEM_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU_RESULT = 2'b10;

    // alu_src_a
    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLD_PC = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;

    // alu_src_b
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // imm_src
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // alu_op
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_imm_src_decoder.sv
// Immediate-format decoder: maps the instruction opcode to the imm_src
// select used by the immediate extender. Purely combinational.
// Ports:
//   opcode  in  7  instr[6:0]
//   imm_src out 2  00 I, 01 S, 10 B, 11 J
module mc_imm_src_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [1:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (opcode)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main sequencer of the multi-cycle RV32I core. A Moore FSM steps the shared
// ALU, memory and register file through fetch/decode/execute/writeback,
// drives the datapath selects and write enables, counts retired
// instructions and flags unsupported opcodes.
//
// Build option: define MC_MEM_WAIT_EN to add the mem_ready input; FETCH,
// MEMREAD and MEMWRITE then stall until memory reports completion.
//
// Ports:
//   clk, rst (async, active-high)
//   opcode, zero, [mem_ready]          inputs from datapath / memory
//   pc_write, adr_src, mem_write,
//   ir_write, reg_write                enables and address select
//   result_src, alu_src_a, alu_src_b,
//   imm_src, alu_op                    datapath selects
//   instr_retired, illegal_instr       one-cycle event pulses
//   instret                            retired-instruction counter
module multicycle_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 zero,
`ifdef MC_MEM_WAIT_EN
    input  logic                 mem_ready,
`endif
    output logic                 pc_write,
    output logic                 adr_src,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic [1:0]           result_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           imm_src,
    output logic [1:0]           alu_op,
    output logic                 instr_retired,
    output logic                 illegal_instr,
    output logic [INSTRET_W-1:0] instret
);

    state_e                 state_q, state_d;
    logic [INSTRET_W-1:0]   instret_q, instret_d;
    logic                   pc_update;
    logic                   branch;
    logic                   mem_rdy;

`ifdef MC_MEM_WAIT_EN
    assign mem_rdy = mem_ready;
`else
    // Without the handshake every memory access completes in one cycle.
    assign mem_rdy = 1'b1;
`endif

    mc_imm_src_decoder u_imm_src_decoder (
        .opcode  (opcode),
        .imm_src (imm_src)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_update     = 1'b0;
        branch        = 1'b0;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        result_src    = RES_ALU_OUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALUOP_ADD;
        instr_retired = 1'b0;
        illegal_instr = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC+4 is computed every fetch cycle, but the IR and PC
                // only load once the instruction word is actually there.
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALUOP_ADD;
                result_src = RES_ALU_RESULT;
                ir_write   = mem_rdy;
                pc_update  = mem_rdy;
                state_d    = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Speculatively form old_pc + imm for a possible branch.
                alu_src_a = SRCA_OLD_PC;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        illegal_instr = 1'b1;
                        state_d       = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
                state_d   = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                result_src = RES_ALU_OUT;
                state_d    = mem_rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src    = RES_MEM_DATA;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                // The write strobe stays up for the whole access; the store
                // only counts as retired on the completing cycle.
                adr_src       = 1'b1;
                result_src    = RES_ALU_OUT;
                mem_write     = 1'b1;
                instr_retired = mem_rdy;
                state_d       = mem_rdy ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src    = RES_ALU_OUT;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end
            S_BEQ: begin
                // Target was latched in alu_out during DECODE; the compare
                // runs now and pc_write is qualified by zero.
                alu_src_a     = SRCA_RS1;
                alu_src_b     = SRCB_RS2;
                alu_op        = ALUOP_SUB;
                result_src    = RES_ALU_OUT;
                branch        = 1'b1;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end
            S_JAL: begin
                // Jump to the DECODE target while old_pc+4 is formed as the
                // link value; ALUWB writes it and retires the instruction.
                alu_src_a  = SRCA_OLD_PC;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALUOP_ADD;
                result_src = RES_ALU_OUT;
                pc_update  = 1'b1;
                state_d    = S_ALUWB;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign pc_write = pc_update | (branch & zero);

    // Modulo-2^INSTRET_W counter: all-ones plus one wraps naturally.
    always_comb begin
        instret_d = instret_q + INSTRET_W'(instr_retired);
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

    localparam int IW = 4;

    localparam logic [6:0] T_LW  = 7'b0000011;
    localparam logic [6:0] T_SW  = 7'b0100011;
    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_BEQ = 7'b1100011;
    localparam logic [6:0] T_JAL = 7'b1101111;

`ifdef MC_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    opcode;
    logic          zero;
    logic          mem_ready;
    logic          pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0]    result_src, alu_src_a, alu_src_b, imm_src, alu_op;
    logic          instr_retired, illegal_instr;
    logic [IW-1:0] instret;

    int checks = 0;
    int failures = 0;
    int model_cnt = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.INSTRET_W(IW)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .zero          (zero),
`ifdef MC_MEM_WAIT_EN
        .mem_ready     (mem_ready),
`endif
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .imm_src       (imm_src),
        .alu_op        (alu_op),
        .instr_retired (instr_retired),
        .illegal_instr (illegal_instr),
        .instret       (instret)
    );

    // Directed program: op and zero mode (0/1 forced, 2 random)
    logic [6:0] dir_op [9] = '{T_R, T_BEQ, T_BEQ, T_LW, T_SW, T_I, T_JAL, 7'b1111111, 7'b0000000};
    int         dir_zf [9] = '{2, 1, 0, 2, 2, 2, 2, 2, 2};

    // Packed view: {pc_write,adr_src,mem_write,ir_write,reg_write,result_src,a,b,alu_op,retired,illegal}
    function automatic logic [14:0] pk(input bit pcw, input bit adr, input bit mw, input bit ir,
                                       input bit rw, input logic [1:0] rs, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] aop,
                                       input bit ret, input bit ill);
        return {pcw, adr, mw, ir, rw, rs, a, b, aop, ret, ill};
    endfunction

    function automatic logic [14:0] obs();
        return {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                alu_src_a, alu_src_b, alu_op, instr_retired, illegal_instr};
    endfunction

    function automatic bit legal(input logic [6:0] op);
        return op == T_LW || op == T_SW || op == T_R || op == T_I || op == T_BEQ || op == T_JAL;
    endfunction

    function automatic int len_of(input logic [6:0] op);
        if (op == T_LW) return 5;
        if (op == T_BEQ) return 3;
        if (legal(op)) return 4;
        return 2;
    endfunction

    // Cycles where memory is accessed: instruction fetch and the data access
    function automatic bit can_stall(input logic [6:0] op, input int k);
        return (k == 0) || (k == 3 && (op == T_LW || op == T_SW));
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        if (op == T_SW) return 2'b01;
        if (op == T_BEQ) return 2'b10;
        if (op == T_JAL) return 2'b11;
        return 2'b00;
    endfunction

    // Expected outputs on cycle k of an instruction (k=0 fetch, k=1 decode)
    function automatic logic [14:0] exp_vec(input logic [6:0] op, input int k, input bit z, input bit rdy);
        logic [14:0] wb;
        logic [14:0] addr;
        wb   = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
        addr = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 2'd0, 1'b0, 1'b0);
        if (k == 0) return pk(rdy, 1'b0, 1'b0, rdy, 1'b0, 2'd2, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0);
        if (k == 1) return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 2'd0, 1'b0, !legal(op));
        if (op == T_LW) begin
            if (k == 2) return addr;
            if (k == 3) return pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
            return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
        end
        if (op == T_SW) begin
            if (k == 2) return addr;
            return pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, rdy, 1'b0);
        end
        if (op == T_R) return (k == 2) ? pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 2'd2, 1'b0, 1'b0) : wb;
        if (op == T_I) return (k == 2) ? pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 2'd2, 1'b0, 1'b0) : wb;
        if (op == T_BEQ) return pk(z, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 2'd1, 1'b1, 1'b0);
        if (op == T_JAL) return (k == 2) ? pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 2'd0, 1'b0, 1'b0) : wb;
        return '0;
    endfunction

    task automatic test_reset();
        logic [14:0] ev;
        rst = 1'b1; opcode = T_R; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        ev = exp_vec(T_R, 0, 1'b0, 1'b1);
        checks++;
        if (obs() !== ev) begin
            failures++;
            $display("FAIL reset_outputs actual=%b required=%b", obs(), ev);
        end
        checks++;
        if (instret !== '0) begin
            failures++;
            $display("FAIL reset_instret actual=%0d required=0", instret);
        end
        @(negedge clk);
        rst = 1'b0;
        model_cnt = 0;
    endtask

    task automatic test_reset_mid_exec();
        logic [14:0] ev_f;
        logic [14:0] ev_x;
        ev_f = exp_vec(T_R, 0, 1'b0, 1'b1);
        ev_x = exp_vec(T_R, 2, 1'b0, 1'b1);
        opcode = T_R; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (obs() !== ev_x) begin
            failures++;
            $display("FAIL mid_reset_in_execr actual=%b required=%b", obs(), ev_x);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (obs() !== ev_f || instret !== '0) begin
            failures++;
            $display("FAIL mid_reset_async actual=%b/%0d required=%b/0", obs(), instret, ev_f);
        end
        model_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ir_write !== 1'b1 || reg_write !== 1'b0 || instret !== '0) begin
            failures++;
            $display("FAIL mid_reset_release ir_write=%b reg_write=%b instret=%0d required 1 0 0",
                     ir_write, reg_write, instret);
        end
        checks++;
        if (obs() !== ev_f) begin
            failures++;
            $display("FAIL mid_reset_fetch actual=%b required=%b", obs(), ev_f);
        end
    endtask

    // mode 0: directed table, 1: back-to-back R-type, 2: random mix
    task automatic test_instr_stream(input string name, input int mode, input int n);
        logic [6:0]  op;
        logic [14:0] ev;
        int          zf;
        int          waits;
        bit          rdy;
        bit          z;
        for (int i = 0; i < n; i++) begin
            zf = 2;
            if (mode == 0) begin
                op = dir_op[i];
                zf = dir_zf[i];
            end else if (mode == 1) begin
                op = T_R;
            end else begin
                case ($urandom_range(0, 6))
                    0: op = T_LW;
                    1: op = T_SW;
                    2: op = T_R;
                    3: op = T_I;
                    4: op = T_BEQ;
                    5: op = T_JAL;
                    default: begin
                        op = 7'($urandom);
                        while (legal(op)) op = 7'($urandom);
                    end
                endcase
            end
            for (int k = 0; k < len_of(op); k++) begin
                waits = (WAIT_EN && can_stall(op, k)) ? $urandom_range(0, 3) : 0;
                for (int w = 0; w <= waits; w++) begin
                    rdy = (w == waits);
                    z = (zf == 2) ? 1'($urandom) : (zf == 1);
                    opcode = op;
                    zero = z;
                    if (can_stall(op, k)) mem_ready = rdy;
                    else mem_ready = WAIT_EN ? 1'($urandom) : 1'b1;
                    ev = exp_vec(op, k, z, rdy);
                    #1;
                    checks++;
                    if (obs() !== ev) begin
                        failures++;
                        $display("FAIL %s outputs op=%b cyc=%0d wait=%0d actual=%b required=%b",
                                 name, op, k, w, obs(), ev);
                    end
                    checks++;
                    if (imm_src !== imm_of(op)) begin
                        failures++;
                        $display("FAIL %s imm_src op=%b actual=%b required=%b", name, op, imm_src, imm_of(op));
                    end
                    checks++;
                    if (instret !== IW'(model_cnt)) begin
                        failures++;
                        $display("FAIL %s instret op=%b cyc=%0d actual=%0d required=%0d",
                                 name, op, k, instret, IW'(model_cnt));
                    end
                    if (ev[1]) model_cnt++;
                    @(negedge clk);
                end
            end
        end
        if (mode == 1) begin
            #1;
            checks++;
            if (instret !== '0) begin
                failures++;
                $display("FAIL %s wrap actual=%0d required=0", name, instret);
            end
        end
    endtask

    initial begin
        test_reset();
        test_instr_stream("directed", 0, 9);
        test_reset_mid_exec();
        test_instr_stream("wrap", 1, 16);
        test_instr_stream("random", 2, 60);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
